task_frame_ctrl: RTL and testbench
==================================

TASK_FRAME_CTRL -- requirements
Module: task_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_TASKS, default 16, number of task instances addressed (max 16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, result FIFO depth in bytes (power of 2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536, result wait limit in clocks.
REQ-004 SHALL have ports (clock and reset first): i_clk in 1 clock; i_rst_n in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports i_rx_valid in 1, i_rx_data in 8: one byte per valid cycle from the UART receiver, no backpressure.
REQ-006 SHALL have ports o_task_sel out 4 (selected task index), o_valid out 1, o_first out 1, o_last out 1, o_data out 8: the task input stream.
REQ-007 SHALL have ports i_res_valid in 1, i_res_last in 1, i_res_data in 8: the output stream of the selected task.
REQ-008 SHALL have ports o_tx_valid out 1, i_tx_ready in 1, o_tx_data out 8: byte stream to the UART transmitter.
REQ-009 SHALL have ports o_busy out 1, o_err out 1 (one-cycle pulse), o_ovf out 1 (sticky).

Function
REQ-010 SHALL parse frames as: header byte (bits[3:0] task ID, bits[7:4] ignored), length byte LEN, then LEN payload bytes.
REQ-011 SHALL implement states IDLE -> HDR_LEN -> PAYLOAD -> WAIT_RES -> IDLE, plus DROP.
REQ-012 SHALL, in IDLE on i_rx_valid, latch ID into o_task_sel and go to HDR_LEN.
REQ-013 SHALL, in HDR_LEN on i_rx_valid: LEN=0 -> pulse o_err, go IDLE; ID>=NUM_TASKS -> pulse o_err, go DROP with LEN bytes to discard; else go PAYLOAD.
REQ-014 SHALL forward each PAYLOAD byte to o_data with o_valid exactly one clock after i_rx_valid, o_first on byte 1, o_last on byte LEN (both on the same byte when LEN=1).
REQ-015 SHALL enter WAIT_RES on the cycle the LEN-th byte is accepted, and leave it for IDLE on i_res_valid && i_res_last.
REQ-016 SHALL, in DROP, discard i_rx_valid bytes until LEN consumed, then go IDLE, never asserting o_valid.
REQ-017 SHALL, in WAIT_RES, discard any i_rx_valid byte and pulse o_err for it.
REQ-018 SHALL push every i_res_valid byte into the result FIFO in any state; if full, drop the byte and set o_ovf until reset.
REQ-019 SHALL drive o_tx_valid when FIFO non-empty with o_tx_data = head byte; pop on o_tx_valid && i_tx_ready; simultaneous push and pop at full SHALL succeed without loss.
REQ-020 SHALL drive o_busy = (state != IDLE).
REQ-021 SHALL hold o_task_sel stable from HDR_LEN until return to IDLE.

Reset
REQ-022 SHALL, on i_rst_n low (any time, mid-frame included), go IDLE, empty FIFO, and drive o_valid, o_first, o_last, o_tx_valid, o_busy, o_err, o_ovf = 0, o_data, o_task_sel = 0.
REQ-023 SHALL treat the first byte after reset release as a header.

Configuration
REQ-024 SHALL, with TASK_FRAME_CTRL_TIMEOUT_EN defined, count clocks in WAIT_RES and after TIMEOUT_CYCLES without i_res_last pulse o_err and go IDLE.
REQ-025 SHALL, without TASK_FRAME_CTRL_TIMEOUT_EN, wait in WAIT_RES indefinitely and omit the counter.

Structure
REQ-026 SHALL place the state enum and frame-field constants (ID mask, header/length positions) in package task_frame_pkg.
REQ-027 SHALL implement the result FIFO as sub-module task_frame_fifo (sync, first-word-fall-through, registered full/empty).

Verification
REQ-028 Frame 0x03,0x02,0xAA,0xBB -> o_task_sel=3; o_data 0xAA(first),0xBB(last) one clock after each rx byte; o_busy until i_res_last.
REQ-029 Header 0x1F (ID 15, NUM_TASKS=4), LEN 3, 3 bytes -> one o_err pulse, no o_valid, IDLE after third byte; next frame handled normally.
REQ-030 Header 0x01, LEN 0 -> o_err pulse, IDLE; no o_valid.
REQ-031 i_tx_ready=0, 65 result bytes with FIFO_DEPTH=64 -> o_ovf=1, first 64 bytes delivered in order once i_tx_ready=1.
REQ-032 Reset asserted after 1 of 4 payload bytes -> all outputs 0 immediately; next byte after release parsed as header.
REQ-033 TIMEOUT_EN, TIMEOUT_CYCLES=16, no result -> o_err pulse 16 clocks after entering WAIT_RES, then IDLE.

Source files
------------

// File: rtl/task_frame_pkg.sv
// Shared FSM state encodings and frame header field layout for the task frame controller.
package task_frame_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR_LEN  = 3'd1;
  localparam logic [2:0] ST_PAYLOAD  = 3'd2;
  localparam logic [2:0] ST_WAIT_RES = 3'd3;
  localparam logic [2:0] ST_DROP     = 3'd4;

  localparam logic [7:0] HDR_ID_MASK = 8'h0F;
  localparam int         HDR_ID_LSB  = 0;
  localparam int         HDR_ID_MSB  = 3;

  function automatic logic [3:0] hdr_task_id(input logic [7:0] hdr);
    logic [7:0] masked;
    masked = hdr & HDR_ID_MASK;
    return masked[HDR_ID_MSB:HDR_ID_LSB];
  endfunction

endpackage

// File: rtl/task_frame_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module task_frame_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + CNT_ONE;
    else if (!do_push && do_pop)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/task_frame_ctrl.sv
// Frame parser that routes UART frames to a selected task and buffers its results for TX.
// Define TASK_FRAME_CTRL_TIMEOUT_EN to bound the wait for a task result.
module task_frame_ctrl
  import task_frame_pkg::*;
#(
  parameter int NUM_TASKS      = 16,
  parameter int FIFO_DEPTH     = 64,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic [3:0] o_task_sel,
  output logic       o_valid,
  output logic       o_first,
  output logic       o_last,
  output logic [7:0] o_data,
  input  logic       i_res_valid,
  input  logic       i_res_last,
  input  logic [7:0] i_res_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_err,
  output logic       o_ovf
);

  localparam logic [4:0] NUM_TASKS_L = 5'(NUM_TASKS);

  logic [2:0] state;
  logic [7:0] remaining;
  logic       first_pending;
  logic       id_bad;
  logic       timeout_hit;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       tx_pop;

  assign id_bad = ({1'b0, o_task_sel} >= NUM_TASKS_L);
  assign o_busy = (state != ST_IDLE);

`ifdef TASK_FRAME_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] wait_timer;

  assign timeout_hit = (state == ST_WAIT_RES) && (wait_timer == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      wait_timer <= '0;
    else if (state != ST_WAIT_RES)
      wait_timer <= '0;
    else
      wait_timer <= wait_timer + TO_ONE;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      first_pending <= 1'b0;
      o_task_sel    <= '0;
      o_valid       <= 1'b0;
      o_first       <= 1'b0;
      o_last        <= 1'b0;
      o_data        <= '0;
      o_err         <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            o_task_sel <= hdr_task_id(i_rx_data);
            state      <= ST_HDR_LEN;
          end
        end
        ST_HDR_LEN: begin
          if (i_rx_valid) begin
            remaining <= i_rx_data;
            if (i_rx_data == 8'd0) begin
              o_err <= 1'b1;
              state <= ST_IDLE;
            end else if (id_bad) begin
              o_err <= 1'b1;
              state <= ST_DROP;
            end else begin
              first_pending <= 1'b1;
              state         <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (i_rx_valid) begin
            o_valid       <= 1'b1;
            o_data        <= i_rx_data;
            o_first       <= first_pending;
            o_last        <= (remaining == 8'd1);
            first_pending <= 1'b0;
            remaining     <= remaining - 8'd1;
            if (remaining == 8'd1) state <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          // Stray RX bytes are flagged even on the cycle the result completes.
          if (i_rx_valid || (timeout_hit && !(i_res_valid && i_res_last)))
            o_err <= 1'b1;
          if ((i_res_valid && i_res_last) || timeout_hit)
            state <= ST_IDLE;
        end
        ST_DROP: begin
          if (i_rx_valid) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_pop = o_tx_valid && i_tx_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_ovf <= 1'b0;
    else if (i_res_valid && fifo_full && !tx_pop)
      o_ovf <= 1'b1;
  end

  task_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_res_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (i_res_valid),
    .push_data (i_res_data),
    .pop       (tx_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_tx_valid = !fifo_empty;
  assign o_tx_data  = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_task_frame_ctrl.sv
// Scoreboard bench for task_frame_ctrl: expected payload/result bytes are queued as stimulus is driven.
module tb_task_frame_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_rx_valid = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic [3:0] o_task_sel;
  logic       o_valid, o_first, o_last;
  logic [7:0] o_data;
  logic       i_res_valid = 1'b0, i_res_last = 1'b0;
  logic [7:0] i_res_data = '0;
  logic       o_tx_valid;
  logic       i_tx_ready = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_busy, o_err, o_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] rx_q[$];
  logic [7:0] tx_q[$];

  task_frame_ctrl #(.NUM_TASKS(4), .FIFO_DEPTH(64), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_task_sel(o_task_sel), .o_valid(o_valid), .o_first(o_first), .o_last(o_last), .o_data(o_data),
    .i_res_valid(i_res_valid), .i_res_last(i_res_last), .i_res_data(i_res_data),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_err(o_err), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = '0;
  endtask

  task automatic send_res(input logic [7:0] b, input logic last);
    i_res_valid = 1'b1;
    i_res_data  = b;
    i_res_last  = last;
    tick();
    i_res_valid = 1'b0;
    i_res_last  = 1'b0;
    i_res_data  = '0;
  endtask

  task automatic do_reset();
    i_rx_valid = 1'b0; i_res_valid = 1'b0; i_res_last = 1'b0; i_tx_ready = 1'b0;
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    rx_q.delete();
    tx_q.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_first, o_last, o_tx_valid, o_busy, o_err, o_ovf, o_data, o_task_sel, o_tx_data} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_in: got v=%b busy=%b err=%b ovf=%b data=%h sel=%h, expected all 0",
               o_valid, o_busy, o_err, o_ovf, o_data, o_task_sel);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({o_valid, o_tx_valid, o_busy, o_err, o_ovf, o_task_sel} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_after: got v=%b txv=%b busy=%b err=%b ovf=%b sel=%h, expected 0",
               o_valid, o_tx_valid, o_busy, o_err, o_ovf, o_task_sel);
    end
  endtask

  task automatic test_frame();
    logic [7:0] pl [2];
    pl[0] = 8'hAA;
    pl[1] = 8'hBB;
    do_reset();
    send_byte(8'h03);
    n_cmp++;
    if (o_task_sel !== 4'd3 || o_busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL frame_hdr: got sel=%0d busy=%b expected sel=3 busy=1", o_task_sel, o_busy);
    end
    send_byte(8'h02);
    for (int i = 0; i < 2; i++) begin
      rx_q.push_back({(i == 0), (i == 1), pl[i]});
      send_byte(pl[i]);
      n_cmp++;
      if (rx_q.size() == 0 || o_valid !== 1'b1 || {o_first, o_last, o_data} !== rx_q[0]) begin
        n_bad++;
        $display("[TB] FAIL frame_payload: got v=%b f/l/d=%h expected v=1 f/l/d=%h",
                 o_valid, {o_first, o_last, o_data}, {(i == 0), (i == 1), pl[i]});
      end
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL frame_extra_valid: got %b expected 0", o_valid);
    end
    repeat (3) tick();
    n_cmp++;
    if (o_busy !== 1'b1 || o_task_sel !== 4'd3) begin
      n_bad++;
      $display("[TB] FAIL frame_wait: got busy=%b sel=%0d expected busy=1 sel=3", o_busy, o_task_sel);
    end
    tx_q.push_back(8'h5A);
    send_res(8'h5A, 1'b1);
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL frame_done: got busy=%b expected 0", o_busy);
    end
    i_tx_ready = 1'b1;
    n_cmp++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== tx_q[0]) begin
      n_bad++;
      $display("[TB] FAIL frame_tx: got v=%b d=%h expected v=1 d=%h", o_tx_valid, o_tx_data, tx_q[0]);
    end
    void'(tx_q.pop_front());
    tick();
    i_tx_ready = 1'b0;
    n_cmp++;
    if (o_tx_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL frame_tx_empty: got v=%b expected 0", o_tx_valid);
    end
  endtask

  task automatic test_bad_id();
    do_reset();
    send_byte(8'h1F);
    send_byte(8'h03);
    n_cmp++;
    if (o_err !== 1'b1 || o_busy !== 1'b1 || o_task_sel !== 4'hF) begin
      n_bad++;
      $display("[TB] FAIL bad_id_err: got err=%b busy=%b sel=%h expected err=1 busy=1 sel=f",
               o_err, o_busy, o_task_sel);
    end
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h40 + 8'(i));
      n_cmp++;
      if (o_valid !== 1'b0 || o_err !== 1'b0 || o_busy !== (i < 2)) begin
        n_bad++;
        $display("[TB] FAIL bad_id_drop%0d: got v=%b err=%b busy=%b expected v=0 err=0 busy=%b",
                 i, o_valid, o_err, o_busy, (i < 2));
      end
    end
    send_byte(8'h02);
    send_byte(8'h01);
    rx_q.push_back({1'b1, 1'b1, 8'h77});
    send_byte(8'h77);
    n_cmp++;
    if (rx_q.size() == 0 || o_valid !== 1'b1 || {o_first, o_last, o_data} !== rx_q[0] || o_task_sel !== 4'd2) begin
      n_bad++;
      $display("[TB] FAIL bad_id_next: got v=%b f/l/d=%h sel=%0d expected v=1 f/l/d=%h sel=2",
               o_valid, {o_first, o_last, o_data}, o_task_sel, {1'b1, 1'b1, 8'h77});
    end
    if (rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  task automatic test_len_zero();
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    n_cmp++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL len_zero: got err=%b busy=%b v=%b expected err=1 busy=0 v=0", o_err, o_busy, o_valid);
    end
    tick();
    n_cmp++;
    if (o_err !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL len_zero_pulse: got err=%b expected 0", o_err);
    end
  endtask

  task automatic test_wait_res_err();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'hEE);
    n_cmp++;
    if (o_err !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL wait_res_rx: got err=%b v=%b busy=%b expected err=1 v=0 busy=1", o_err, o_valid, o_busy);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      tx_q.push_back(8'(i));
      send_res(8'(i), 1'b0);
    end
    tx_q.push_back(8'hC3);
    i_tx_ready = 1'b1;
    n_cmp++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== tx_q[0]) begin
      n_bad++;
      $display("[TB] FAIL full_head: got v=%b d=%h expected v=1 d=%h", o_tx_valid, o_tx_data, tx_q[0]);
    end
    void'(tx_q.pop_front());
    send_res(8'hC3, 1'b0);
    n_cmp++;
    if (o_ovf !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL full_push_pop_ovf: got %b expected 0", o_ovf);
    end
    for (int i = 0; i < 70 && tx_q.size() != 0; i++) begin
      n_cmp++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== tx_q[0]) begin
        n_bad++;
        $display("[TB] FAIL full_drain%0d: got v=%b d=%h expected v=1 d=%h", i, o_tx_valid, o_tx_data, tx_q[0]);
      end
      void'(tx_q.pop_front());
      tick();
    end
    i_tx_ready = 1'b0;
    n_cmp++;
    if (o_tx_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL full_drain_empty: got v=%b expected 0", o_tx_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 65; i++) begin
      if (i < 64) tx_q.push_back(8'(i * 3 + 1));
      send_res(8'(i * 3 + 1), 1'b0);
      if (i >= 63) begin
        n_cmp++;
        if (o_ovf !== (i == 64)) begin
          n_bad++;
          $display("[TB] FAIL ovf_after_%0d: got %b expected %b", i + 1, o_ovf, (i == 64));
        end
      end
    end
    i_tx_ready = 1'b1;
    for (int i = 0; i < 70 && tx_q.size() != 0; i++) begin
      n_cmp++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== tx_q[0]) begin
        n_bad++;
        $display("[TB] FAIL ovf_drain%0d: got v=%b d=%h expected v=1 d=%h", i, o_tx_valid, o_tx_data, tx_q[0]);
      end
      void'(tx_q.pop_front());
      tick();
    end
    i_tx_ready = 1'b0;
    n_cmp++;
    if (o_tx_valid !== 1'b0 || o_ovf !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL ovf_end: got v=%b ovf=%b expected v=0 ovf=1", o_tx_valid, o_ovf);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h11);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_first, o_last, o_tx_valid, o_busy, o_err, o_ovf, o_data, o_task_sel} !== '0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: got v=%b f=%b busy=%b data=%h sel=%h expected all 0",
               o_valid, o_first, o_busy, o_data, o_task_sel);
    end
    tick();
    i_rst_n = 1'b1;
    send_byte(8'h01);
    n_cmp++;
    if (o_task_sel !== 4'd1 || o_busy !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset_hdr: got sel=%0d busy=%b v=%b expected sel=1 busy=1 v=0",
               o_task_sel, o_busy, o_valid);
    end
    send_byte(8'h01);
    rx_q.push_back({1'b1, 1'b1, 8'h99});
    send_byte(8'h99);
    n_cmp++;
    if (rx_q.size() == 0 || o_valid !== 1'b1 || {o_first, o_last, o_data} !== rx_q[0]) begin
      n_bad++;
      $display("[TB] FAIL mid_reset_payload: got v=%b f/l/d=%h expected v=1 f/l/d=%h",
               o_valid, {o_first, o_last, o_data}, {1'b1, 1'b1, 8'h99});
    end
    if (rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h42);
`ifdef TASK_FRAME_CTRL_TIMEOUT_EN
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_cmp++;
      if (o_err !== (k == 16) || o_busy !== (k < 16)) begin
        n_bad++;
        $display("[TB] FAIL timeout_k%0d: got err=%b busy=%b expected err=%b busy=%b",
                 k, o_err, o_busy, (k == 16), (k < 16));
      end
    end
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_cmp++;
      if (o_err !== 1'b0 || o_busy !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL no_timeout_k%0d: got err=%b busy=%b expected err=0 busy=1", k, o_err, o_busy);
      end
    end
`endif
  endtask

  initial begin
    #2;
    test_reset();
    test_frame();
    test_bad_id();
    test_len_zero();
    test_wait_res_err();
    test_full_push_pop();
    test_overflow();
    test_reset_mid_frame();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
